// File: rtl/seq_multiplier_top.sv
// seq_multiplier_top: shift-add unsigned multiplier, start/done handshake, half-select output
// Optional overflow flag port ovf enabled by defining MUL_OVF_FLAG_EN.
module seq_multiplier_top #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   out
`ifdef MUL_OVF_FLAG_EN
    ,
    output logic               ovf
`endif
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH:0] sum;
    logic [CNT_W-1:0] cnt;
    logic sel_q, accept, last;
    always_comb begin
        accept = start && (state != RUN);
        last = cnt == CNT_W'(WIDTH - 1);
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
        acc_nx = {sum, acc[WIDTH-1:1]};
        state_nx = (state == RUN) ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
        busy = state == RUN;
        done = state == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // Result registers load on the final RUN step so they update exactly on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            a_q <= '0;
            b_q <= '0;
            cnt <= '0;
            sel_q <= 1'b0;
            product <= '0;
            out <= '0;
`ifdef MUL_OVF_FLAG_EN
            ovf <= 1'b0;
`endif
        end else if (accept) begin
            a_q <= a;
            b_q <= b;
            sel_q <= sel;
            acc <= '0;
            cnt <= '0;
        end else if (state == RUN) begin
            acc <= acc_nx;
            b_q <= b_q >> 1;
            cnt <= cnt + 1'b1;
            if (last) begin
                product <= acc_nx;
                out <= sel_q ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];
`ifdef MUL_OVF_FLAG_EN
                ovf <= |acc_nx[2*WIDTH-1:WIDTH];
`endif
            end
        end
    end
endmodule

// File: tb/tb_seq_multiplier_top.sv
// tb_seq_multiplier_top: scoreboard bench, directed WIDTH=4 cases and random WIDTH=8 ops vs a*b
module tb_seq_multiplier_top;
    typedef struct {
        logic [15:0] p;
        logic [7:0]  o;
        logic        v;
        int          t;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start4 = 1'b0, sel4 = 1'b0, busy4, done4;
    logic [3:0] a4 = '0, b4 = '0, o4;
    logic [7:0] p4;
    logic start8 = 1'b0, sel8 = 1'b0, busy8, done8;
    logic [7:0] a8 = '0, b8 = '0, o8;
    logic [15:0] p8;
`ifdef MUL_OVF_FLAG_EN
    logic ovf4, ovf8;
`endif
    exp_t q4[$], q8[$];
    int total = 0, bad = 0, cyc = 0, bc4 = 0, bc8 = 0;

    seq_multiplier_top #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .sel(sel4),
        .busy(busy4), .done(done4), .product(p4), .out(o4)
`ifdef MUL_OVF_FLAG_EN
        , .ovf(ovf4)
`endif
    );
    seq_multiplier_top #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .sel(sel8),
        .busy(busy8), .done(done8), .product(p8), .out(o8)
`ifdef MUL_OVF_FLAG_EN
        , .ovf(ovf8)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic exp_t model(input int w, input int x, input int y, input int s);
        exp_t e;
        int p;
        p = x * y;
        e.p = 16'(p);
        e.o = 8'(s ? p >> w : p % (1 << w));
        e.v = (p >> w) != 0;
        e.t = cyc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) bc4 = 0;
        else begin
            if (busy4 && done4) chk("excl4", 1, 0);
            if (busy4) bc4++;
            if (done4) begin
                if (q4.size() == 0) chk("spurious_done4", 1, 0);
                else begin
                    exp_t e;
                    e = q4.pop_front();
                    chk("product4", p4, e.p[7:0]);
                    chk("out4", o4, e.o[3:0]);
`ifdef MUL_OVF_FLAG_EN
                    chk("ovf4", ovf4, e.v);
`endif
                    chk("latency4", cyc - e.t, 5);
                    chk("busy_cycles4", bc4, 4);
                end
                bc4 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) bc8 = 0;
        else begin
            if (busy8 && done8) chk("excl8", 1, 0);
            if (busy8) bc8++;
            if (done8) begin
                if (q8.size() == 0) chk("spurious_done8", 1, 0);
                else begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("product8", p8, e.p);
                    chk("out8", o8, e.o);
`ifdef MUL_OVF_FLAG_EN
                    chk("ovf8", ovf8, e.v);
`endif
                    chk("latency8", cyc - e.t, 9);
                    chk("busy_cycles8", bc8, 8);
                end
                bc8 = 0;
            end
        end
    end

    task automatic op4(input int x, input int y, input int s, input bit hold);
        int k = 0;
        while (busy4 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) chk("timeout4", 1, 0);
        a4 = 4'(x);
        b4 = 4'(y);
        sel4 = s[0];
        start4 = 1'b1;
        q4.push_back(model(4, x, y, s));
        @(negedge clk);
        if (!hold) start4 = 1'b0;
    endtask

    task automatic op8(input int x, input int y, input int s, input bit hold);
        int k = 0;
        while (busy8 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) chk("timeout8", 1, 0);
        a8 = 8'(x);
        b8 = 8'(y);
        sel8 = s[0];
        start8 = 1'b1;
        q8.push_back(model(8, x, y, s));
        @(negedge clk);
        if (!hold) start8 = 1'b0;
    endtask

    initial begin
        int k;
        bit h;
        repeat (3) @(negedge clk);
        chk("rst_product4", p4, 0);
        chk("rst_out4", o4, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_product8", p8, 0);
        rst_n = 1'b1;
        @(negedge clk);
        op4(7, 9, 0, 0);
        op4(15, 15, 1, 0);
        op4(0, 13, 0, 0);
        op4(3, 5, 0, 0);
        @(negedge clk);
        start4 = 1'b1;
        a4 = 4'd2;
        b4 = 4'd2;
        sel4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        sel4 = 1'b0;
        for (int i = 0; i < 6; i++) op4($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), 1);
        start4 = 1'b0;
        op4(6, 7, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_product4", p4, 0);
        chk("midrst_out4", o4, 0);
        chk("midrst_busy4", busy4, 0);
        chk("midrst_done4", done4, 0);
        q4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op4(6, 6, 1, 0);
        for (int i = 0; i < 1000; i++) begin
            h = ($urandom_range(0, 2) == 0);
            op8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), h);
            if (!h) begin
                if ($urandom_range(0, 3) == 0) begin
                    start8 = 1'b1;
                    a8 = 8'($urandom);
                    b8 = 8'($urandom);
                    sel8 = ~sel8;
                    @(negedge clk);
                    start8 = 1'b0;
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        start8 = 1'b0;
        op8(255, 255, 1, 0);
        op8(0, 0, 0, 0);
        k = 0;
        while ((q4.size() != 0 || q8.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drain", q4.size() + q8.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
